// File: rtl/mtm_alu_serializer.sv
// mtm_alu_serializer: shifts ALU result words and control bytes out as 11-bit serial frames
module mtm_alu_serializer #(
  parameter int DATA_BYTES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [8*DATA_BYTES-1:0] C,
  input  logic [7:0]              CTL_in,
  input  logic                    valid_in,
  output logic                    ready_out,
  output logic                    sout
);
  localparam int BW = DATA_BYTES > 1 ? $clog2(DATA_BYTES) : 1;
  typedef enum logic [1:0] {IDLE, DATA, CTL} state_t;
  state_t state, state_n;
  logic [3:0] bit_cnt, bit_cnt_n;
  logic [BW-1:0] byte_cnt, byte_cnt_n;
  logic [8*DATA_BYTES-1:0] c_q, c_n;
  logic [7:0] ctl_q, ctl_n;
  logic sout_n, ready_n, last, last_n, accept;
  logic [10:0] frame;
  assign accept = valid_in && ready_out;
  // Data bytes leave MSB-first by shifting the captured word up after each frame
  assign frame = {1'b0, state == CTL, state == CTL ? ctl_q : c_q[8*DATA_BYTES-1 -: 8], 1'b1};
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      byte_cnt  <= '0;
      c_q       <= '0;
      ctl_q     <= '0;
      sout      <= 1'b1;
      ready_out <= 1'b1;
      last      <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      byte_cnt  <= byte_cnt_n;
      c_q       <= c_n;
      ctl_q     <= ctl_n;
      sout      <= sout_n;
      ready_out <= ready_n;
      last      <= last_n;
    end
  end
  // last marks the cycle the final stop bit is on the line; accepting then starts the next frame with no gap
  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    byte_cnt_n = byte_cnt;
    c_n        = c_q;
    ctl_n      = ctl_q;
    sout_n     = sout;
    ready_n    = ready_out;
    last_n     = 1'b0;
    case (state)
      IDLE: begin
        sout_n = 1'b1;
        if (accept) begin
          c_n        = C;
          ctl_n      = CTL_in;
          ready_n    = 1'b0;
          state_n    = CTL_in[7] ? CTL : DATA;
          byte_cnt_n = '0;
          bit_cnt_n  = {3'b000, last};
          sout_n     = !last;
        end
      end
      default: begin
        sout_n    = frame[4'd10 - bit_cnt];
        bit_cnt_n = bit_cnt == 4'd10 ? 4'd0 : bit_cnt + 4'd1;
        if (bit_cnt == 4'd10 && state == DATA) begin
          c_n        = c_q << 8;
          state_n    = byte_cnt == BW'(DATA_BYTES - 1) ? CTL : DATA;
          byte_cnt_n = byte_cnt + 1'b1;
        end
        if (bit_cnt == 4'd10 && state == CTL) begin
          state_n = IDLE;
          ready_n = 1'b1;
          last_n  = 1'b1;
        end
      end
    endcase
  end
endmodule

// File: tb/tb_mtm_alu_serializer.sv
// tb_mtm_alu_serializer: scoreboard bench; frames expected by stimulus are checked by a serial-line monitor
module tb_mtm_alu_serializer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] C = '0;
  logic [7:0] CTL_in = '0;
  logic valid_in = 1'b0;
  logic ready_out, sout;
  int total = 0;
  int passed = 0;
  logic [10:0] exp_q[$];
  logic [10:0] sh = '0;
  int nb = 0;

  mtm_alu_serializer #(.DATA_BYTES(4)) dut (
    .clk(clk), .rst_n(rst_n), .C(C), .CTL_in(CTL_in),
    .valid_in(valid_in), .ready_out(ready_out), .sout(sout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [66:0] act, input logic [66:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // monitor: assemble frames from the line and compare against the scoreboard
  always @(negedge clk) begin
    if (!rst_n) nb = 0;
    else if (nb > 0 || sout == 1'b0) begin
      sh = {sh[9:0], sout};
      nb++;
      if (nb == 11) begin
        nb = 0;
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL unexpected_frame: got %b expected none", sh);
        end else check("frame", 67'(sh), 67'(exp_q.pop_front()));
      end
    end
  end

  task automatic push_data(input logic [10:0] f0, f1, f2, f3, f4);
    exp_q.push_back(f0); exp_q.push_back(f1); exp_q.push_back(f2);
    exp_q.push_back(f3); exp_q.push_back(f4);
  endtask

  task automatic send(input logic [31:0] c, input logic [7:0] ctl);
    int n = 0;
    @(negedge clk);
    C = c; CTL_in = ctl; valid_in = 1'b1;
    while (!ready_out && n < 200) begin @(negedge clk); n++; end
    if (!ready_out) begin total++; $display("FAIL send_timeout: ready_out got 0 expected 1"); end
    @(posedge clk);
    #1 valid_in = 1'b0;
  endtask

  // count cycles ready_out stays low after acceptance; optionally scramble inputs meanwhile
  task automatic measure(input string name, input int n_exp, input bit scramble);
    int lo = 0;
    @(negedge clk);
    check({name, "_idle_before_start"}, 67'(sout), 67'(1'b1));
    while (!ready_out && lo < 200) begin
      lo++;
      if (scramble) begin C = $urandom; CTL_in = 8'($urandom); end
      @(negedge clk);
    end
    check({name, "_ready_low"}, 67'(lo), 67'(n_exp));
    @(negedge clk);
    @(negedge clk);
    check({name, "_idle_after"}, 67'(sout), 67'(1'b1));
    check({name, "_sb_empty"}, 67'(exp_q.size()), 67'(0));
  endtask

  logic [66:0] v;
  logic [66:0] v_exp;

  initial begin
    // reset held with valid asserted
    valid_in = 1'b1; C = 32'h12345678; CTL_in = 8'h0B;
    repeat (3) begin
      @(negedge clk);
      check("rst_sout", 67'(sout), 67'(1'b1));
      check("rst_ready", 67'(ready_out), 67'(1'b1));
    end
    rst_n = 1'b1; valid_in = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_idle", 67'(sout), 67'(1'b1));

    // data response
    push_data(11'b0_0_00010010_1, 11'b0_0_00110100_1, 11'b0_0_01010110_1,
              11'b0_0_01111000_1, 11'b0_1_00001011_1);
    send(32'h12345678, 8'h0B);
    measure("data", 55, 1'b0);

    // error responses
    exp_q.push_back(11'b0_1_10100101_1);
    send(32'hFFFFFFFF, 8'hA5);
    measure("err_a5", 11, 1'b0);
    exp_q.push_back(11'b0_1_11111111_1);
    send(32'h00000000, 8'hFF);
    measure("err_ff", 11, 1'b0);

    // back-to-back: valid held high through a data response
    push_data(11'b0_0_00010010_1, 11'b0_0_00110100_1, 11'b0_0_01010110_1,
              11'b0_0_01111000_1, 11'b0_1_00001011_1);
    exp_q.push_back(11'b0_1_11001001_1);
    v_exp = {1'b1, 11'b0_0_00010010_1, 11'b0_0_00110100_1, 11'b0_0_01010110_1,
             11'b0_0_01111000_1, 11'b0_1_00001011_1, 11'b0_1_11001001_1};
    @(negedge clk);
    C = 32'h12345678; CTL_in = 8'h0B; valid_in = 1'b1;
    @(posedge clk);
    #1 CTL_in = 8'hC9; C = 32'hFFFFFFFF;
    v = '0;
    for (int i = 0; i <= 66; i++) begin
      @(negedge clk);
      v = {v[65:0], sout};
      if (i == 54) check("b2b_busy", 67'(ready_out), 67'(1'b0));
      if (i == 55) check("b2b_ready_on_stop", 67'(ready_out), 67'(1'b1));
      if (i == 56) begin
        check("b2b_accepted", 67'(ready_out), 67'(1'b0));
        valid_in = 1'b0;
      end
    end
    check("b2b_stream", v, v_exp);
    check("b2b_ready_end", 67'(ready_out), 67'(1'b1));
    repeat (2) @(negedge clk);
    check("b2b_idle_after", 67'(sout), 67'(1'b1));
    check("b2b_sb_empty", 67'(exp_q.size()), 67'(0));

    // reset in the middle of a data response
    push_data(11'b0_0_11011110_1, 11'b0_0_10101101_1, 11'b0_0_10111110_1,
              11'b0_0_11101111_1, 11'b0_1_00110101_1);
    send(32'hDEADBEEF, 8'h35);
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("midrst_sout", 67'(sout), 67'(1'b1));
    check("midrst_ready", 67'(ready_out), 67'(1'b1));
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("midrst_idle", 67'(sout), 67'(1'b1));
    end
    push_data(11'b0_0_11011110_1, 11'b0_0_10101101_1, 11'b0_0_10111110_1,
              11'b0_0_11101111_1, 11'b0_1_00110101_1);
    send(32'hDEADBEEF, 8'h35);
    measure("after_rst", 55, 1'b0);

    // inputs change every cycle after acceptance
    push_data(11'b0_0_00000000_1, 11'b0_0_00000000_1, 11'b0_0_11111111_1,
              11'b0_0_00000000_1, 11'b0_1_00010010_1);
    send(32'h0000FF00, 8'h12);
    measure("stable", 55, 1'b1);

    begin
      int n = 0;
      while ((exp_q.size() != 0 || nb != 0) && n < 200) begin @(negedge clk); n++; end
    end
    check("final_sb_empty", 67'(exp_q.size()), 67'(0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
